// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: feeds an external full-adder cell one bit pair per
// clock (LSB first), recirculating its carry, and assembles {cout, sum}.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             accept_c;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] sum_sr_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             last_c;

  assign last_c = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE or DONE
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (last_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand shifters, carry recirculation, bit counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
    end else if (accept_c) begin
      a_sr_q   <= op_a;
      b_sr_q   <= op_b;
      sum_sr_q <= '0;
      carry_q  <= cin;
      cnt_q    <= '0;
    end else if (state_q == RUN) begin
      a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
      b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
      sum_sr_q <= {fa_sum, sum_sr_q[WIDTH-1:1]};
      carry_q  <= fa_carry;
      if (last_c) begin
        sum  <= {fa_sum, sum_sr_q[WIDTH-1:1]};
        cout <= fa_carry;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Cell drive is gated so the adder sees zeros outside RUN
  assign fa_a = (state_q == RUN) & a_sr_q[0];
  assign fa_b = (state_q == RUN) & b_sr_q[0];
  assign fa_c = (state_q == RUN) & carry_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: 8-bit directed vectors plus an
// exhaustive 3-bit sweep, each DUT paired with a behavioural full-adder cell.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst;

  logic       start8, cin8, fa_a8, fa_b8, fa_c8, fa_sum8, fa_carry8, busy8, done8, cout8;
  logic [7:0] op_a8, op_b8, sum8;

  logic       start3, cin3, fa_a3, fa_b3, fa_c3, fa_sum3, fa_carry3, busy3, done3, cout3;
  logic [2:0] op_a3, op_b3, sum3;

  int         total = 0;
  int         bad   = 0;
  logic [8:0] q8[$];
  logic [3:0] q3[$];
  logic [8:0] last_res = 9'h000;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op_a(op_a8), .op_b(op_b8), .cin(cin8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_c(fa_c8), .fa_sum(fa_sum8), .fa_carry(fa_carry8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .op_a(op_a3), .op_b(op_b3), .cin(cin3),
    .fa_a(fa_a3), .fa_b(fa_b3), .fa_c(fa_c3), .fa_sum(fa_sum3), .fa_carry(fa_carry3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  // External full-adder cells
  assign fa_sum8   = fa_a8 ^ fa_b8 ^ fa_c8;
  assign fa_carry8 = (fa_a8 & fa_b8) | (fa_a8 & fa_c8) | (fa_b8 & fa_c8);
  assign fa_sum3   = fa_a3 ^ fa_b3 ^ fa_c3;
  assign fa_carry3 = (fa_a3 & fa_b3) | (fa_a3 & fa_c3) | (fa_b3 & fa_c3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Monitors: pop and compare whenever a DUT flags done
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) chk("unexpected_done8", 32'(done8), 32'd0);
      else chk("result8", 32'({cout8, sum8}), 32'(q8.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (done3) begin
      if (q3.size() == 0) chk("unexpected_done3", 32'(done3), 32'd0);
      else chk("result3", 32'({cout3, sum3}), 32'(q3.pop_front()));
    end
  end

  // One 8-bit operation; inj>=0 pulses a stray start at that RUN cycle,
  // b2b issues start in the current (DONE) cycle without an idle gap
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [8:0] exp, input int inj, input bit b2b);
    logic [8:0] prev;
    logic       carry;
    int         cyc;
    int         busy_n;
    prev = last_res;
    if (!b2b) @(negedge clk);
    start8 = 1'b1;
    op_a8  = a;
    op_b8  = b;
    cin8   = c;
    q8.push_back(exp);
    carry  = c;
    cyc    = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      cyc++;
      start8 = 1'b0;
      if (busy8) begin
        if (busy_n < 8) begin
          chk("fa_abc", 32'({fa_a8, fa_b8, fa_c8}), 32'({a[busy_n], b[busy_n], carry}));
          carry = maj(a[busy_n], b[busy_n], carry);
        end
        if (busy_n == 0) chk("result_held", 32'({cout8, sum8}), 32'(prev));
        if (busy_n == inj) begin
          start8 = 1'b1;
          op_a8  = 8'h12;
          op_b8  = 8'h34;
        end
        busy_n++;
      end
    end while (!done8 && cyc < 20);
    chk("latency", 32'(cyc), 32'd9);
    chk("busy_len", 32'(busy_n), 32'd8);
    last_res = exp;
  endtask

  // Global watchdog
  initial begin
    #1ms;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ndone;
    int w;
    rst = 1'b1;
    start8 = 1'b0; op_a8 = '0; op_b8 = '0; cin8 = 1'b0;
    start3 = 1'b0; op_a3 = '0; op_b3 = '0; cin3 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_result", 32'({cout8, sum8}), 32'd0);
    chk("rst_fa", 32'({fa_a8, fa_b8, fa_c8}), 32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);
    rst = 1'b0;

    // T1 / T2: basic sums and carry propagation
    run_op8(8'h0F, 8'h01, 1'b0, 9'h010, -1, 1'b0);
    run_op8(8'hFF, 8'h01, 1'b0, 9'h100, -1, 1'b0);
    run_op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, -1, 1'b0);
    // T3: stray start during RUN is ignored
    run_op8(8'h0F, 8'h01, 1'b0, 9'h010, 3, 1'b0);
    // T4: back-to-back, second start issued in the DONE cycle
    run_op8(8'h80, 8'h80, 1'b0, 9'h100, -1, 1'b0);
    run_op8(8'hA5, 8'h5A, 1'b0, 9'h0FF, -1, 1'b1);

    // T5: reset at RUN cycle 4 aborts without a done pulse
    @(negedge clk);
    start8 = 1'b1; op_a8 = 8'h33; op_b8 = 8'h44; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("abort_running", 32'(busy8), 32'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_result", 32'({cout8, sum8}), 32'd0);
    chk("abort_fa", 32'({fa_a8, fa_b8, fa_c8}), 32'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    last_res = 9'h000;
    run_op8(8'h3C, 8'h4B, 1'b1, 9'h088, -1, 1'b0);

    // T6: exhaustive 3-bit sweep against a behavioural adder
    for (int i = 0; i < 128; i++) begin
      logic [2:0] a;
      logic [2:0] b;
      logic       c;
      a = 3'(i);
      b = 3'(i >> 3);
      c = 1'(i >> 6);
      @(negedge clk);
      start3 = 1'b1; op_a3 = a; op_b3 = b; cin3 = c;
      q3.push_back({1'b0, a} + {1'b0, b} + 4'(c));
      @(negedge clk);
      start3 = 1'b0;
      w = 0;
      while (!done3 && w < 10) begin
        @(negedge clk);
        w++;
      end
      chk("dut3_timeout", 32'(done3), 32'd1);
    end

    repeat (3) @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
